// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side and EX-side signal bundle of the ID/EX pipeline register
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_shamt;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [1:0]        id_alu_op;
  logic [5:0]        id_funct;
  logic              id_alu_src;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;

  logic [DATA_W-1:0] ex_in1;
  logic [DATA_W-1:0] ex_in2;
  logic [2:0]        ex_alu_ctrl;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs_addr, id_rt_addr,
           id_alu_op, id_funct, id_alu_src, id_rd_addr,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    input  ex_in1, ex_in2, ex_alu_ctrl, ex_store_data, ex_valid, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs_addr, id_rt_addr,
           id_alu_op, id_funct, id_alu_src, id_rd_addr,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    output ex_in1, ex_in2, ex_alu_ctrl, ex_store_data, ex_valid, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register: ALU control decode, operand select, stall/flush, bubble counter
// Optional operand forwarding from EX/MEM and MEM/WB is enabled by defining FORWARD_EN.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
`ifdef FORWARD_EN
  input  logic              fwd_mem_we,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              fwd_wb_we,
  input  logic [REG_AW-1:0] fwd_wb_rd,
  input  logic [DATA_W-1:0] fwd_wb_data,
`endif
  id_ex_stage_if.slave      bus,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [2:0]        ctrl;
    logic [DATA_W-1:0] store;
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_t;

  ex_t              ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [2:0]        ctrl;
  logic              is_shift;

  // Operand source: EX/MEM beats MEM/WB, register 0 is never forwarded.
  always_comb begin
    rs_val = bus.id_rs_data;
    rt_val = bus.id_rt_data;
`ifdef FORWARD_EN
    if (bus.id_rs_addr != '0) begin
      if (fwd_mem_we && fwd_mem_rd == bus.id_rs_addr)
        rs_val = fwd_mem_data;
      else if (fwd_wb_we && fwd_wb_rd == bus.id_rs_addr)
        rs_val = fwd_wb_data;
    end
    if (bus.id_rt_addr != '0) begin
      if (fwd_mem_we && fwd_mem_rd == bus.id_rt_addr)
        rt_val = fwd_mem_data;
      else if (fwd_wb_we && fwd_wb_rd == bus.id_rt_addr)
        rt_val = fwd_wb_data;
    end
`endif
  end

  always_comb begin
    ctrl = 3'b000;
    case (bus.id_alu_op)
      2'b00: ctrl = 3'b000;
      2'b01: ctrl = 3'b001;
      2'b11: ctrl = 3'b011;
      default: begin
        case (bus.id_funct)
          6'b100000: ctrl = 3'b000;
          6'b100010: ctrl = 3'b001;
          6'b100100: ctrl = 3'b010;
          6'b100101: ctrl = 3'b011;
          6'b000000: ctrl = 3'b100;
          6'b000010: ctrl = 3'b101;
          6'b101010: ctrl = 3'b110;
          default:   ctrl = 3'b111;
        endcase
      end
    endcase
  end

  assign is_shift = (ctrl == 3'b100) || (ctrl == 3'b101);

  // Priority: flush > stall > load. A flush always counts one bubble.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d  = '0;
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end else if (!stall) begin
      ex_d.in1        = is_shift ? rt_val : rs_val;
      ex_d.in2        = is_shift ? {{(DATA_W-5){1'b0}}, bus.id_shamt}
                                 : (bus.id_alu_src ? bus.id_imm : rt_val);
      ex_d.ctrl       = ctrl;
      ex_d.store      = rt_val;
      ex_d.valid      = bus.id_valid;
      ex_d.rd         = bus.id_rd_addr;
      ex_d.reg_write  = bus.id_valid & bus.id_reg_write;
      ex_d.mem_read   = bus.id_valid & bus.id_mem_read;
      ex_d.mem_write  = bus.id_valid & bus.id_mem_write;
      ex_d.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_in1        = ex_q.in1;
  assign bus.ex_in2        = ex_q.in2;
  assign bus.ex_alu_ctrl   = ex_q.ctrl;
  assign bus.ex_store_data = ex_q.store;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_rd_addr    = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bubble_cnt        = cnt_q;

endmodule
